// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: control-only N:1 AXI write-channel arbiter for one slave port.
// AW requests are arbitrated round-robin. The grant stays locked through the
// AW handshake, the W burst up to WLAST and the B handshake. grant_idx_o
// steers the external AW/W/B data muxes.
// Optional feature: define AXI_ARB_WDT_EN to add a stall watchdog that sets a
// sticky err_o. Without the macro err_o is tied to 0.
module axi_wr_arbiter #(
    parameter int MST_NUM    = 2,
    parameter int IDX_W      = (MST_NUM > 1) ? $clog2(MST_NUM) : 1,
    parameter int WDT_CYCLES = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [MST_NUM-1:0] req_i,
    output logic [MST_NUM-1:0] m_awready_o,
    output logic               s_awvalid_o,
    input  logic               s_awready_i,
    input  logic [MST_NUM-1:0] m_wvalid_i,
    input  logic [MST_NUM-1:0] m_wlast_i,
    output logic [MST_NUM-1:0] m_wready_o,
    output logic               s_wvalid_o,
    output logic               s_wlast_o,
    input  logic               s_wready_i,
    input  logic               s_bvalid_i,
    output logic               s_bready_o,
    output logic [MST_NUM-1:0] m_bvalid_o,
    input  logic [MST_NUM-1:0] m_bready_i,
    output logic [MST_NUM-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_nxt;
    logic [MST_NUM-1:0] grant_q;
    logic [IDX_W-1:0]   grant_idx_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [MST_NUM-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;

    // Granted master's view of the per-master inputs (zero when nothing is granted).
    logic g_req;
    logic g_wvalid;
    logic g_wlast;
    logic g_bready;
    logic aw_hs;
    logic w_hs;
    logic b_hs;

    assign g_req    = |(req_i      & grant_q);
    assign g_wvalid = |(m_wvalid_i & grant_q);
    assign g_wlast  = |(m_wlast_i  & grant_q);
    assign g_bready = |(m_bready_i & grant_q);

    assign aw_hs = s_awvalid_o & s_awready_i;
    assign w_hs  = s_wvalid_o & s_wready_i & s_wlast_o;
    assign b_hs  = s_bvalid_i & s_bready_o;

    assign grant_o     = grant_q;
    assign grant_idx_o = grant_idx_q;

    // Round-robin search: first requester at or above rr_ptr_q, wrapping around.
    always_comb begin
        int   cand;
        logic found;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        pick_oh  = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int k = 0; k < MST_NUM; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= MST_NUM) cand = cand - MST_NUM;
            if (!found && ((req_i & (MST_NUM'(1) << cand)) != '0)) begin
                found    = 1'b1;
                pick_oh  = MST_NUM'(1) << cand;
                pick_idx = IDX_W'(cand);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
            state_q <= state_nxt;
        end
    end

    // Next-state logic: one transaction at a time, AW -> W burst -> B.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: if (req_i != '0) state_nxt = ADDR;
            ADDR: if (aw_hs)       state_nxt = DATA;
            DATA: if (w_hs)        state_nxt = RESP;
            RESP: if (b_hs)        state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Handshake gating: only the granted master, only in the channel's own phase.
    always_comb begin
        s_awvalid_o = 1'b0;
        m_awready_o = '0;
        s_wvalid_o  = 1'b0;
        s_wlast_o   = 1'b0;
        m_wready_o  = '0;
        m_bvalid_o  = '0;
        s_bready_o  = 1'b0;
        case (state_q)
            ADDR: begin
                s_awvalid_o = g_req;
                m_awready_o = grant_q & {MST_NUM{s_awready_i}};
            end
            DATA: begin
                s_wvalid_o = g_wvalid;
                s_wlast_o  = g_wlast & g_wvalid;
                m_wready_o = grant_q & {MST_NUM{s_wready_i}};
            end
            RESP: begin
                m_bvalid_o = grant_q & {MST_NUM{s_bvalid_i}};
                s_bready_o = g_bready;
            end
            default: ;
        endcase
    end

    // Grant register and round-robin pointer: latch the winner in IDLE, release after B.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_q     <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            if (state_q == IDLE && req_i != '0) begin
                grant_q     <= pick_oh;
                grant_idx_q <= pick_idx;
            end else if (state_q == RESP && b_hs) begin
                grant_q  <= '0;
                rr_ptr_q <= (grant_idx_q == IDX_W'(MST_NUM - 1)) ? '0 : grant_idx_q + 1'b1;
            end
        end
    end

`ifdef AXI_ARB_WDT_EN
    localparam logic [15:0] WDT_LIMIT = 16'(WDT_CYCLES);

    logic [15:0] wdt_cnt_q;
    logic        err_q;
    logic        stall;

    // A stall is any DATA/RESP cycle that completes neither a W beat nor the B handshake.
    assign stall = ((state_q == DATA) && !(s_wvalid_o && s_wready_i)) ||
                   ((state_q == RESP) && !b_hs);

    // Stall counter and sticky error: set on the edge where the count reaches the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdt_cnt_q <= '0;
            err_q     <= 1'b0;
        end else if (stall) begin
            if (wdt_cnt_q != 16'hFFFF) wdt_cnt_q <= wdt_cnt_q + 16'd1;
            if (wdt_cnt_q + 16'd1 == WDT_LIMIT) err_q <= 1'b1;
        end else begin
            wdt_cnt_q <= '0;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
